// File: rtl/scratchpad_seq_multi.sv
// Tensor-core scratchpad: NUM_MATS x ROWS row storage driven by an
// instruction FIFO of LOAD / STORE / GEMM / CLEAR operations.
//
// Ports:
//   CLK, nRST              clock, async active-low reset
//   instr_wen/wdata/full   instruction push {op,m0,m1,m2,addr}
//   mem_ren/rvalid/rdata   row read request/ack from memory
//   mem_wen/wack/wdata     row write request/ack to memory
//   mem_addr               row address (addr + r*bytes)
//   array_ready            array accepts a row this cycle
//   weight/input/partial_enable, *_data, *_row_sel  rows to array
//   psumout_en/row_sel/data  psum write-back from array
//   drained                array empty
//   *_complete             single-cycle done pulses
//   busy                   active or FIFO non-empty
module scratchpad_seq_multi #(
  parameter int NUM_MATS     = 4,
  parameter int ROWS         = 4,
  parameter int BITS_PER_ROW = 64,
  parameter int ADDR_W       = 32,
  parameter int FIFO_DEPTH   = 4,
  localparam int MAT_W   = $clog2(NUM_MATS),
  localparam int ROW_W   = $clog2(ROWS),
  localparam int INSTR_W = 2 + 3*MAT_W + ADDR_W
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    instr_wen,
  input  logic [INSTR_W-1:0]      instr_wdata,
  output logic                    instr_full,
  output logic                    mem_ren,
  input  logic                    mem_rvalid,
  input  logic [BITS_PER_ROW-1:0] mem_rdata,
  output logic                    mem_wen,
  input  logic                    mem_wack,
  output logic [BITS_PER_ROW-1:0] mem_wdata,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    array_ready,
  output logic                    weight_enable,
  output logic                    input_enable,
  output logic                    partial_enable,
  output logic [BITS_PER_ROW-1:0] weight_input_data,
  output logic [BITS_PER_ROW-1:0] partial_sum_data,
  output logic [ROW_W-1:0]        weight_input_row_sel,
  output logic [ROW_W-1:0]        partial_sum_row_sel,
  input  logic                    psumout_en,
  input  logic [ROW_W-1:0]        psumout_row_sel,
  input  logic [BITS_PER_ROW-1:0] psumout_data,
  input  logic                    drained,
  output logic                    load_complete,
  output logic                    store_complete,
  output logic                    gemm_complete,
  output logic                    clear_complete,
  output logic                    busy
);

  localparam int BYTES = BITS_PER_ROW / 8;
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W = FA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_GW,
    S_GIN,
    S_GDRAIN,
    S_CLEAR
  } state_t;

  state_t r_state;

  logic [INSTR_W-1:0] r_fifo [FIFO_DEPTH];
  logic [FA_W-1:0]    r_wptr;
  logic [FA_W-1:0]    r_rptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_pop;
  logic               w_push;

  logic [INSTR_W-1:0] w_head;
  logic [1:0]         w_op;
  logic [MAT_W-1:0]   w_m0;
  logic [MAT_W-1:0]   w_m1;
  logic [MAT_W-1:0]   w_m2;
  logic [ADDR_W-1:0]  w_addr;

  logic [BITS_PER_ROW-1:0] r_mem [NUM_MATS][ROWS];
  logic [MAT_W-1:0]        r_m0;
  logic [MAT_W-1:0]        r_m1;
  logic [MAT_W-1:0]        r_m2;
  logic [ADDR_W-1:0]       r_base;
  logic [ROW_W-1:0]        r_row;
  logic [ROW_W-1:0]        w_row_nxt;
  logic                    w_row_last;
  logic [ROW_W:0]          r_pcnt;
  logic                    w_psum_wr;

  assign w_head = r_fifo[r_rptr];
  assign w_op   = w_head[INSTR_W-1 -: 2];
  assign w_m0   = w_head[INSTR_W-3 -: MAT_W];
  assign w_m1   = w_head[INSTR_W-3-MAT_W -: MAT_W];
  assign w_m2   = w_head[ADDR_W +: MAT_W];
  assign w_addr = w_head[ADDR_W-1:0];

  assign instr_full = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0);
  // a pop frees a slot in the same cycle, so a full FIFO still takes it
  assign w_push     = instr_wen && (!instr_full || w_pop);
  assign busy       = (r_state != S_IDLE) || (r_cnt != '0);

  assign w_row_nxt  = r_row + ROW_W'(1);
  assign w_row_last = (r_row == ROW_W'(ROWS-1));
  assign w_psum_wr  = psumout_en &&
                      ((r_state == S_GIN) || (r_state == S_GDRAIN));

  function automatic logic [ADDR_W-1:0] f_row_addr(
    input logic [ADDR_W-1:0] base,
    input logic [ROW_W-1:0]  row
  );
    return base + ADDR_W'(row) * ADDR_W'(BYTES);
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= instr_wdata;
        r_wptr         <= r_wptr + FA_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + FA_W'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state              <= S_IDLE;
      r_m0                 <= '0;
      r_m1                 <= '0;
      r_m2                 <= '0;
      r_base               <= '0;
      r_row                <= '0;
      r_pcnt               <= '0;
      mem_ren              <= 1'b0;
      mem_wen              <= 1'b0;
      mem_wdata            <= '0;
      mem_addr             <= '0;
      weight_enable        <= 1'b0;
      input_enable         <= 1'b0;
      partial_enable       <= 1'b0;
      weight_input_data    <= '0;
      partial_sum_data     <= '0;
      weight_input_row_sel <= '0;
      partial_sum_row_sel  <= '0;
      load_complete        <= 1'b0;
      store_complete       <= 1'b0;
      gemm_complete        <= 1'b0;
      clear_complete       <= 1'b0;
      for (int i = 0; i < NUM_MATS; i++)
        for (int j = 0; j < ROWS; j++)
          r_mem[i][j] <= '0;
    end else begin
      load_complete  <= 1'b0;
      store_complete <= 1'b0;
      gemm_complete  <= 1'b0;
      clear_complete <= 1'b0;

      // placed first so a drain completion in the same cycle
      // still clears the psum counter
      if (w_psum_wr) begin
        r_mem[r_m2][psumout_row_sel] <= psumout_data;
        r_pcnt <= r_pcnt + (ROW_W+1)'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_m0   <= w_m0;
            r_m1   <= w_m1;
            r_m2   <= w_m2;
            r_base <= w_addr;
            r_row  <= '0;
            r_pcnt <= '0;
            unique case (w_op)
              2'b00: begin
                r_state  <= S_LOAD;
                mem_ren  <= 1'b1;
                mem_addr <= w_addr;
              end
              2'b01: begin
                r_state   <= S_STORE;
                mem_wen   <= 1'b1;
                mem_addr  <= w_addr;
                mem_wdata <= r_mem[w_m0][0];
              end
              2'b10: begin
                r_state              <= S_GW;
                weight_enable        <= 1'b1;
                weight_input_data    <= r_mem[w_m0][0];
                weight_input_row_sel <= '0;
              end
              2'b11: begin
                r_state <= S_CLEAR;
              end
            endcase
          end
        end

        S_LOAD: begin
          if (mem_rvalid) begin
            r_mem[r_m0][r_row] <= mem_rdata;
            if (w_row_last) begin
              r_row         <= '0;
              mem_ren       <= 1'b0;
              load_complete <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_row    <= w_row_nxt;
              mem_addr <= f_row_addr(r_base, w_row_nxt);
            end
          end
        end

        S_STORE: begin
          if (mem_wack) begin
            if (w_row_last) begin
              r_row          <= '0;
              mem_wen        <= 1'b0;
              store_complete <= 1'b1;
              r_state        <= S_IDLE;
            end else begin
              r_row     <= w_row_nxt;
              mem_addr  <= f_row_addr(r_base, w_row_nxt);
              mem_wdata <= r_mem[r_m0][w_row_nxt];
            end
          end
        end

        S_GW: begin
          if (array_ready) begin
            if (w_row_last) begin
              r_row                <= '0;
              weight_enable        <= 1'b0;
              input_enable         <= 1'b1;
              partial_enable       <= 1'b1;
              weight_input_data    <= r_mem[r_m1][0];
              partial_sum_data     <= r_mem[r_m2][0];
              weight_input_row_sel <= '0;
              partial_sum_row_sel  <= '0;
              r_state              <= S_GIN;
            end else begin
              r_row                <= w_row_nxt;
              weight_input_data    <= r_mem[r_m0][w_row_nxt];
              weight_input_row_sel <= w_row_nxt;
            end
          end
        end

        S_GIN: begin
          if (array_ready) begin
            if (w_row_last) begin
              r_row          <= '0;
              input_enable   <= 1'b0;
              partial_enable <= 1'b0;
              r_state        <= S_GDRAIN;
            end else begin
              r_row                <= w_row_nxt;
              weight_input_data    <= r_mem[r_m1][w_row_nxt];
              partial_sum_data     <= r_mem[r_m2][w_row_nxt];
              weight_input_row_sel <= w_row_nxt;
              partial_sum_row_sel  <= w_row_nxt;
            end
          end
        end

        S_GDRAIN: begin
          if (r_pcnt == (ROW_W+1)'(ROWS) && drained) begin
            gemm_complete <= 1'b1;
            r_pcnt        <= '0;
            r_state       <= S_IDLE;
          end
        end

        S_CLEAR: begin
          for (int j = 0; j < ROWS; j++)
            r_mem[r_m0][j] <= '0;
          clear_complete <= 1'b1;
          r_state        <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_seq_multi.sv
// Directed bench for scratchpad_seq_multi: load, FIFO fill,
// GEMM with stall, idle psum, delayed store, clear, reset abort.
module tb_scratchpad_seq_multi;

  logic        CLK;
  logic        nRST;
  logic        instr_wen;
  logic [39:0] instr_wdata;
  logic        instr_full;
  logic        mem_ren;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_wen;
  logic        mem_wack;
  logic [63:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        array_ready;
  logic        weight_enable;
  logic        input_enable;
  logic        partial_enable;
  logic [63:0] weight_input_data;
  logic [63:0] partial_sum_data;
  logic [1:0]  weight_input_row_sel;
  logic [1:0]  partial_sum_row_sel;
  logic        psumout_en;
  logic [1:0]  psumout_row_sel;
  logic [63:0] psumout_data;
  logic        drained;
  logic        load_complete;
  logic        store_complete;
  logic        gemm_complete;
  logic        clear_complete;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_row [4];

  scratchpad_seq_multi dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .instr_wen            (instr_wen),
    .instr_wdata          (instr_wdata),
    .instr_full           (instr_full),
    .mem_ren              (mem_ren),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .mem_wen              (mem_wen),
    .mem_wack             (mem_wack),
    .mem_wdata            (mem_wdata),
    .mem_addr             (mem_addr),
    .array_ready          (array_ready),
    .weight_enable        (weight_enable),
    .input_enable         (input_enable),
    .partial_enable       (partial_enable),
    .weight_input_data    (weight_input_data),
    .partial_sum_data     (partial_sum_data),
    .weight_input_row_sel (weight_input_row_sel),
    .partial_sum_row_sel  (partial_sum_row_sel),
    .psumout_en           (psumout_en),
    .psumout_row_sel      (psumout_row_sel),
    .psumout_data         (psumout_data),
    .drained              (drained),
    .load_complete        (load_complete),
    .store_complete       (store_complete),
    .gemm_complete        (gemm_complete),
    .clear_complete       (clear_complete),
    .busy                 (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pat(input int s, input int r);
    return {8'hA0 + 8'(s), 8'(r), 16'hBEEF,
            8'(s), 8'(r), 16'h1234};
  endfunction

  function automatic logic [63:0] psv(input int p);
    return {32'hCAFE0000 + 32'(p), 32'h5A5A5A5A};
  endfunction

  function automatic logic [39:0] mk(
    input logic [1:0]  op,
    input logic [1:0]  a,
    input logic [1:0]  b,
    input logic [1:0]  c,
    input logic [31:0] ad
  );
    return {op, a, b, c, ad};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [39:0] ins);
    instr_wen   = 1'b1;
    instr_wdata = ins;
    tick();
    instr_wen   = 1'b0;
  endtask

  task automatic wait_ren(input string tag);
    int n = 0;
    while (!mem_ren && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(mem_ren), 64'd1);
  endtask

  task automatic wait_wen(input string tag);
    int n = 0;
    while (!mem_wen && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(mem_wen), 64'd1);
  endtask

  task automatic load_rows(
    input int          slot,
    input logic [31:0] base,
    input int          dly
  );
    for (int r = 0; r < 4; r++) begin
      wait_ren("ld_req");
      chk("ld_addr", 64'(mem_addr), 64'(base + 32'(r*8)));
      repeat (dly) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = pat(slot, r);
      tick();
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic store_rows(
    input logic [31:0] base,
    input int          dly
  );
    for (int r = 0; r < 4; r++) begin
      wait_wen("st_req");
      chk("st_addr", 64'(mem_addr), 64'(base + 32'(r*8)));
      chk("st_data", mem_wdata, exp_row[r]);
      for (int d = 0; d < dly; d++) begin
        tick();
        chk("st_hold", mem_wdata, exp_row[r]);
      end
      mem_wack = 1'b1;
      tick();
      mem_wack = 1'b0;
    end
    chk("st_done", 64'(store_complete), 64'd1);
    chk("st_wen_off", 64'(mem_wen), 64'd0);
    tick();
    chk("st_pulse_end", 64'(store_complete), 64'd0);
  endtask

  initial begin
    int w;
    int i;
    int g;
    int nc;
    bit stalled;
    bit seen;

    nRST            = 1'b0;
    instr_wen       = 1'b0;
    instr_wdata     = '0;
    mem_rvalid      = 1'b0;
    mem_rdata       = '0;
    mem_wack        = 1'b0;
    array_ready     = 1'b1;
    psumout_en      = 1'b0;
    psumout_row_sel = '0;
    psumout_data    = '0;
    drained         = 1'b0;
    tick();
    tick();

    chk("rst_ren", 64'(mem_ren), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_we", 64'(weight_enable), 64'd0);
    chk("rst_wdat", weight_input_data, 64'd0);
    chk("rst_full", 64'(instr_full), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ldc", 64'(load_complete), 64'd0);
    nRST = 1'b1;
    tick();

    // 1: LOAD slot 2, one-cycle read latency
    push(mk(2'b00, 2'd2, 2'd0, 2'd0, 32'h1000));
    chk("busy_q", 64'(busy), 64'd1);
    load_rows(2, 32'h1000, 1);
    chk("ld_done", 64'(load_complete), 64'd1);
    chk("ld_ren_off", 64'(mem_ren), 64'd0);
    tick();
    chk("ld_pulse_end", 64'(load_complete), 64'd0);

    // 2: FIFO fill while a LOAD is stalled
    push(mk(2'b00, 2'd1, 2'd0, 2'd0, 32'h2000));
    wait_ren("ld2_req");
    for (int k = 0; k < 5; k++) begin
      instr_wen   = 1'b1;
      instr_wdata = mk(2'b11, 2'd3, 2'd0, 2'd0, 32'h0);
      tick();
      if (k == 2) chk("full_3", 64'(instr_full), 64'd0);
      if (k >= 3) chk("full_4", 64'(instr_full), 64'd1);
    end
    instr_wen = 1'b0;
    load_rows(1, 32'h2000, 0);
    chk("ld2_done", 64'(load_complete), 64'd1);
    chk("full_pop", 64'(instr_full), 64'd1);
    push(mk(2'b11, 2'd3, 2'd0, 2'd0, 32'h0));
    chk("full_pp", 64'(instr_full), 64'd1);
    nc = 0;
    for (int c = 0; c < 30; c++) begin
      if (clear_complete) nc++;
      tick();
    end
    chk("clr_count", 64'(nc), 64'd5);
    chk("idle_busy", 64'(busy), 64'd0);

    // weight matrix into slot 0
    push(mk(2'b00, 2'd0, 2'd0, 2'd0, 32'h3000));
    load_rows(0, 32'h3000, 0);
    chk("ld3_done", 64'(load_complete), 64'd1);
    tick();

    // 3: GEMM 0,1,3 with a two-cycle stall on weight row 2
    push(mk(2'b10, 2'd0, 2'd1, 2'd3, 32'h0));
    w = 0;
    g = 0;
    stalled = 1'b0;
    while (w < 4 && g < 40) begin
      if (w == 2 && !stalled && weight_enable) begin
        stalled = 1'b1;
        array_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          tick();
          chk("stall_we", 64'(weight_enable), 64'd1);
          chk("stall_sel", 64'(weight_input_row_sel), 64'd2);
          chk("stall_dat", weight_input_data, pat(0, 2));
        end
        array_ready = 1'b1;
      end
      if (weight_enable) begin
        chk("gw_sel", 64'(weight_input_row_sel), 64'(w));
        chk("gw_dat", weight_input_data, pat(0, w));
        w++;
      end
      tick();
      g++;
    end
    chk("gw_rows", 64'(w), 64'd4);
    chk("gw_off", 64'(weight_enable), 64'd0);
    i = 0;
    g = 0;
    while (i < 4 && g < 40) begin
      if (input_enable) begin
        chk("gi_pe", 64'(partial_enable), 64'd1);
        chk("gi_sel", 64'(weight_input_row_sel), 64'(i));
        chk("gi_psel", 64'(partial_sum_row_sel), 64'(i));
        chk("gi_dat", weight_input_data, pat(1, i));
        chk("gi_psum", partial_sum_data, 64'd0);
        i++;
      end
      tick();
      g++;
    end
    chk("gi_rows", 64'(i), 64'd4);
    chk("gi_off", 64'(input_enable), 64'd0);
    for (int p = 0; p < 4; p++) begin
      psumout_en      = 1'b1;
      psumout_row_sel = 2'(p);
      psumout_data    = psv(p);
      tick();
    end
    psumout_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (gemm_complete) seen = 1'b1;
      tick();
    end
    chk("gm_early", 64'(seen), 64'd0);
    drained = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (gemm_complete) seen = 1'b1;
    end
    chk("gm_done", 64'(seen), 64'd1);
    drained = 1'b0;

    // 4: psum write-back while idle is ignored
    psumout_en      = 1'b1;
    psumout_row_sel = 2'd0;
    psumout_data    = {64{1'b1}} & 64'hFF;
    tick();
    psumout_en = 1'b0;
    for (int r = 0; r < 4; r++) exp_row[r] = psv(r);
    push(mk(2'b01, 2'd3, 2'd0, 2'd0, 32'h4000));
    store_rows(32'h4000, 0);

    // 5: STORE slot 2 with three-cycle ack delay
    for (int r = 0; r < 4; r++) exp_row[r] = pat(2, r);
    push(mk(2'b01, 2'd2, 2'd0, 2'd0, 32'h5000));
    store_rows(32'h5000, 3);

    // 6: CLEAR slot 2 then STORE it
    push(mk(2'b11, 2'd2, 2'd0, 2'd0, 32'h0));
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (clear_complete) seen = 1'b1;
      tick();
    end
    chk("clr_done", 64'(seen), 64'd1);
    for (int r = 0; r < 4; r++) exp_row[r] = '0;
    push(mk(2'b01, 2'd2, 2'd0, 2'd0, 32'h6000));
    store_rows(32'h6000, 0);

    // reset in the middle of a LOAD
    push(mk(2'b00, 2'd1, 2'd0, 2'd0, 32'h7000));
    wait_ren("ld4_req");
    mem_rvalid = 1'b1;
    mem_rdata  = pat(1, 0);
    tick();
    mem_rvalid = 1'b0;
    chk("ld4_row1", 64'(mem_addr), 64'h7008);
    nRST = 1'b0;
    #1;
    chk("ar_ren", 64'(mem_ren), 64'd0);
    chk("ar_addr", 64'(mem_addr), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    tick();
    nRST = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (load_complete || mem_ren) seen = 1'b1;
      tick();
    end
    chk("ar_quiet", 64'(seen), 64'd0);
    push(mk(2'b01, 2'd0, 2'd0, 2'd0, 32'h8000));
    store_rows(32'h8000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scratchpad_seq_multi.md
Name: scratchpad_seq_multi

Overview:
- Parametrised next-generation scratchpad for the tensor core: holds NUM_MATS matrices of ROWS rows, each BITS_PER_ROW wide.
- Executes an instruction FIFO of LOAD / STORE / GEMM / CLEAR ops against that storage.
- Sits between the memory-side load/store unit and the systolic array: feeds weight, input and partial-sum rows, and writes drained psum rows back.
- New versus the previous generation: matrix count, row count and FIFO depth are parameters; GEMM takes independent weight, input and psum slots; there is a CLEAR op; load and store use per-row request/acknowledge.

Parameters:
- NUM_MATS, 4, matrix slots (power of 2, >=2); MAT_W = $clog2(NUM_MATS)
- ROWS, 4, rows per matrix (power of 2); ROW_W = $clog2(ROWS)
- BITS_PER_ROW, 64, bits per row (multiple of 8)
- ADDR_W, 32, memory address width
- FIFO_DEPTH, 4, instruction FIFO entries (power of 2)
- INSTR_W, derived, 2+3*MAT_W+ADDR_W; fields {op[1:0], m0, m1, m2, addr}

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- instr_wen  in  1  push instruction
- instr_wdata  in  INSTR_W  instruction
- instr_full  out  1  FIFO full
- mem_ren  out  1  row read request
- mem_rvalid  in  1  read data valid / acknowledge
- mem_rdata  in  BITS_PER_ROW  read data
- mem_wen  out  1  row write request
- mem_wack  in  1  write acknowledge
- mem_wdata  out  BITS_PER_ROW  write data
- mem_addr  out  ADDR_W  row address
- array_ready  in  1  array can accept a row this cycle
- weight_enable, input_enable, partial_enable  out  1 each  row valid strobes
- weight_input_data, partial_sum_data  out  BITS_PER_ROW  row data
- weight_input_row_sel, partial_sum_row_sel  out  ROW_W  row index
- psumout_en  in  1  psum row write-back
- psumout_row_sel  in  ROW_W  psum row index
- psumout_data  in  BITS_PER_ROW  psum row
- drained  in  1  array empty
- load_complete, store_complete, gemm_complete, clear_complete  out  1 each  single-cycle done pulses
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (nRST low, asynchronous): all outputs 0; FIFO empty; state IDLE; row counter and psum counter 0; storage contents zeroed.
- FIFO:
  - instr_full = (count == FIFO_DEPTH).
  - A push while full is dropped, except when a pop occurs in the same cycle; then the push is accepted.
- FSM pops only in IDLE with FIFO non-empty; decode takes one cycle, so the first action is on the cycle after the pop. One instruction is in flight at a time. op 00 LOAD, 01 STORE, 10 GEMM, 11 CLEAR.
- Row address for LOAD/STORE: mem_addr = addr + r*(BITS_PER_ROW/8).
- LOAD (dest m0):
  - Hold mem_ren with mem_addr for row r.
  - On mem_rvalid, write mem_rdata into m0 row r and increment r.
  - After row ROWS-1: drop mem_ren the next cycle, pulse load_complete, go to IDLE.
- STORE (src m0): same sequencing with mem_wen and mem_wdata = m0 row r; advances on mem_wack; pulses store_complete.
- GEMM_W: weight_enable=1, weight_input_data = m0 row r, row_sel = r. Advance r only while array_ready=1; the strobe is held while array_ready=0. ROWS accepted rows, then go to GEMM_IN.
- GEMM_IN:
  - input_enable=1 and partial_enable=1.
  - weight_input_data = m1 row r; partial_sum_data = m2 row r; both row_sels = r.
  - Same array_ready stall rules as GEMM_W; ROWS rows, then go to GEMM_DRAIN.
- Psum write-back: psumout_en writes m2[psumout_row_sel] and increments the psum counter. It is accepted in GEMM_IN and GEMM_DRAIN only and ignored in all other states.
  - A same-cycle read and write of one row returns the old value on the output.
- GEMM_DRAIN: when psum counter == ROWS and drained=1, pulse gemm_complete, clear the counter, go to IDLE.
- CLEAR: zero all rows of m0 in one cycle, pulse clear_complete the next cycle, go to IDLE.
- Counters wrap at ROWS and are cleared on every instruction start. Slot aliasing (m0==m1 etc.) is legal and has no special handling.
- A reset mid-instruction aborts it; no completion pulse is issued and storage is zeroed.

Test Plan:
1. Reset, then push LOAD m0=2 addr=0x1000 with mem_rvalid returned 1 cycle after each request -> mem_addr 0x1000, 0x1008, 0x1010, 0x1018; slot 2 holds the data; a single load_complete pulse.
2. Push 5 instructions back-to-back with FIFO_DEPTH=4 and no pops -> instr_full=1 after the 4th; the 5th is dropped; a push alongside a pop when full is accepted.
3. GEMM m0=0,m1=1,m2=3 with array_ready low 2 cycles mid-GEMM_W -> weight_enable and row_sel held during the stall; exactly 4 weight rows then 4 input/psum rows; 4 psumout writes land in slot 3; gemm_complete only after drained=1.
4. psumout_en asserted in IDLE with data 0xFF -> no storage change.
5. STORE m0=2 with mem_wack delayed 3 cycles per row -> mem_wdata is stable while waiting; store_complete after the 4th ack; data matches test 1.
6. CLEAR m0=2 then STORE m0=2 -> all-zero rows written; nRST pulse during a LOAD -> outputs 0, no load_complete.
